ltc2344_sample_scheduler: RTL

Sequences the LTC2344 CMOS read controller at a programmable sample rate. Generates the controller's external trigger, latches the softspan word for each conversion, and watches the controller's busy/data-ready outputs. Captures the four channel words into a one-entry valid/ready output stage. Sits between the system register/config logic and the ADC controller, in the serialClock domain.

---
 rtl/ltc2344_pkg.sv | 21 ++
 rtl/ltc2344_period_timer.sv | 34 +++
 rtl/ltc2344_sample_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ltc2344_pkg.sv
// Shared types and constants for the LTC2344 sample scheduler.
// Holds the scheduler FSM encoding and the 16-bit saturating counter helper.
package ltc2344_pkg;

   localparam int SOFTSPAN_W = 12;
   localparam int NCH        = 4;
   localparam int MIN_PERIOD = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_TRIGGER   = 3'd2,
      ST_CONVERT   = 3'd3,
      ST_CAPTURE   = 3'd4
   } sched_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/ltc2344_period_timer.sv
// Free-running sample-period counter; emits a one-cycle tick at each wrap.
// Periods below MIN_PERIOD are clamped so the ADC always has time to convert.
module ltc2344_period_timer
   import ltc2344_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             serialClock,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] wrap_val;

   assign wrap_val = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD - 1)
                                                   : period - CNT_W'(1);

   // >= keeps the counter from running away if period shrinks below the count
   assign tick = enable && (cnt_reg >= wrap_val);

   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (!enable || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ltc2344_sample_scheduler.sv
// Periodic trigger/capture sequencer for the LTC2344 read controller.
// Define OVERSAMPLE_AVG_EN to average 2^AVG_LOG2 captures per emitted sample.
module ltc2344_sample_scheduler
   import ltc2344_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int DATA_W   = 16,
   parameter int TIMEOUT  = 4096,
   parameter int AVG_LOG2 = 2
) (
   input  logic                  serialClock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  single_shot,
   input  logic [CNT_W-1:0]      period,
   input  logic [SOFTSPAN_W-1:0] softspan_cfg,
   output logic                  adc_trig,
   output logic [SOFTSPAN_W-1:0] adc_softspan,
   input  logic                  adc_busy,
   input  logic                  adc_data_rdy,
   input  logic [DATA_W-1:0]     adc_data0,
   input  logic [DATA_W-1:0]     adc_data1,
   input  logic [DATA_W-1:0]     adc_data2,
   input  logic [DATA_W-1:0]     adc_data3,
   output logic [DATA_W-1:0]     sample0,
   output logic [DATA_W-1:0]     sample1,
   output logic [DATA_W-1:0]     sample2,
   output logic [DATA_W-1:0]     sample3,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic [15:0]           overrun_cnt,
   output logic [15:0]           timeout_cnt,
   output logic                  overflow
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   sched_state_e      state_reg, state_next;
   logic              tick;
   logic              abort;
   logic              trig_entry;
   logic              timeout_hit;
   logic              data_rdy_prev_reg;
   logic              data_rdy_rise;
   logic              capture;
   logic              emit;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [DATA_W-1:0] adc_data   [NCH];
   logic [DATA_W-1:0] sample_reg [NCH];

   assign adc_data[0] = adc_data0;
   assign adc_data[1] = adc_data1;
   assign adc_data[2] = adc_data2;
   assign adc_data[3] = adc_data3;
   assign sample0     = sample_reg[0];
   assign sample1     = sample_reg[1];
   assign sample2     = sample_reg[2];
   assign sample3     = sample_reg[3];

   ltc2344_period_timer #(
      .CNT_W (CNT_W)
   ) u_period_timer (
      .serialClock (serialClock),
      .reset       (reset),
      .enable      (enable),
      .period      (period),
      .tick        (tick)
   );

   assign timeout_hit   = (to_cnt_reg == TO_W'(TIMEOUT - 1));
   assign data_rdy_rise = adc_data_rdy && !data_rdy_prev_reg;
   assign capture       = (state_reg == ST_CAPTURE);
   assign trig_entry    = (state_next == ST_TRIGGER) && (state_reg != ST_TRIGGER);

   always_comb begin
      state_next = state_reg;
      abort      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable)           state_next = ST_WAIT_TICK;
            else if (single_shot) state_next = ST_TRIGGER;
         end
         ST_WAIT_TICK: begin
            if (!enable)   state_next = ST_IDLE;
            else if (tick) state_next = ST_TRIGGER;
         end
         ST_TRIGGER: begin
            if (adc_busy)         state_next = ST_CONVERT;
            else if (timeout_hit) abort = 1'b1;
         end
         ST_CONVERT: begin
            if (data_rdy_rise)    state_next = ST_CAPTURE;
            else if (timeout_hit) abort = 1'b1;
         end
         ST_CAPTURE: state_next = enable ? ST_WAIT_TICK : ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
      if (abort) state_next = enable ? ST_WAIT_TICK : ST_IDLE;
   end

   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         adc_trig          <= 1'b0;
         adc_softspan      <= '0;
         to_cnt_reg        <= '0;
         data_rdy_prev_reg <= 1'b0;
         overrun_cnt       <= '0;
         timeout_cnt       <= '0;
      end else begin
         state_reg         <= state_next;
         data_rdy_prev_reg <= adc_data_rdy;
         // The timeout window spans both TRIGGER and CONVERT, measured from trigger entry
         if (trig_entry) begin
            adc_trig     <= 1'b1;
            adc_softspan <= softspan_cfg;
            to_cnt_reg   <= '0;
         end else begin
            if (state_next != ST_TRIGGER) adc_trig <= 1'b0;
            if (state_reg == ST_TRIGGER || state_reg == ST_CONVERT)
               to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end
         if (tick && state_reg != ST_WAIT_TICK) overrun_cnt <= sat_inc16(overrun_cnt);
         if (abort) timeout_cnt <= sat_inc16(timeout_cnt);
      end
   end

`ifdef OVERSAMPLE_AVG_EN
   localparam int ACC_W = DATA_W + AVG_LOG2;

   logic [AVG_LOG2-1:0] grp_cnt_reg;
   logic                enable_prev_reg;
   logic                acc_clear;

   assign emit      = capture && (grp_cnt_reg == '1);
   assign acc_clear = abort || (enable_prev_reg && !enable);

   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) begin
         grp_cnt_reg     <= '0;
         enable_prev_reg <= 1'b0;
      end else begin
         enable_prev_reg <= enable;
         if (emit || acc_clear) grp_cnt_reg <= '0;
         else if (capture)      grp_cnt_reg <= grp_cnt_reg + AVG_LOG2'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] acc_sum;

         assign acc_sum = acc_reg + ACC_W'(adc_data[gi]);

         always_ff @(posedge serialClock or posedge reset) begin
            if (reset) begin
               acc_reg        <= '0;
               sample_reg[gi] <= '0;
            end else begin
               if (emit || acc_clear) acc_reg <= '0;
               else if (capture)      acc_reg <= acc_sum;
               if (emit) sample_reg[gi] <= DATA_W'(acc_sum >> AVG_LOG2);
            end
         end
      end
   endgenerate
`else
   assign emit = capture;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         always_ff @(posedge serialClock or posedge reset) begin
            if (reset)        sample_reg[gi] <= '0;
            else if (capture) sample_reg[gi] <= adc_data[gi];
         end
      end
   endgenerate
`endif

   // A new result always lands; an unread one being replaced is flagged
   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) begin
         sample_valid <= 1'b0;
         overflow     <= 1'b0;
      end else if (emit) begin
         sample_valid <= 1'b1;
         if (sample_valid && !sample_ready) overflow <= 1'b1;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

endmodule
